// File: rtl/mio_pkg.sv
// mio_pkg: shared constants for the CPU memory/IO responder.
//   - register addresses of the GPIO and timer blocks (word aligned)
//   - bit positions inside TCTRL
//   - FSM state encoding used by mio_responder
package mio_pkg;

    localparam logic [31:0] ADDR_LED     = 32'hE000_0000;
    localparam logic [31:0] ADDR_SW      = 32'hE000_0004;
    localparam logic [31:0] ADDR_TRELOAD = 32'hF000_0000;
    localparam logic [31:0] ADDR_TCOUNT  = 32'hF000_0004;
    localparam logic [31:0] ADDR_TCTRL   = 32'hF000_0008;

    localparam int unsigned TCTRL_EN   = 0;
    localparam int unsigned TCTRL_PEND = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mio_responder_if.sv
// mio_responder_if: CPU memory/IO request bus.
//   cpu_mio       request valid (CPU -> responder)
//   mem_w         1 = write, 0 = read
//   addr_bus      byte address
//   data_from_cpu write data
//   data_to_cpu   read data, valid while mio_ready = 1
//   mio_ready     one-cycle completion pulse
interface mio_responder_if;

    logic        cpu_mio;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        mio_ready;

    modport master (
        output cpu_mio, mem_w, addr_bus, data_from_cpu,
        input  data_to_cpu, mio_ready
    );

    modport slave (
        input  cpu_mio, mem_w, addr_bus, data_from_cpu,
        output data_to_cpu, mio_ready
    );

endinterface

// File: rtl/mio_ram.sv
// mio_ram: single-port synchronous data RAM, 32-bit words.
//   clk    clock
//   en     access enable (read and/or write this edge)
//   we     word write enable, qualified by en
//   addr   word address
//   wdata  write data
//   rdata  registered read data (old contents on a write), held while en = 0
// Contents are deliberately not reset.
module mio_ram #(
    parameter  int unsigned RAM_WORDS = 1024,
    localparam int unsigned AW        = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mio_responder.sv
// mio_responder: bus-side responder for the CPU memory/IO port.
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   bus      CPU request bus (slave side)
//   int_out  level interrupt: timer pending & enable
//   sw_in    board switches (asynchronous, synchronized here)
//   led_out  LED register
// Targets: data RAM at 0 .. RAM_WORDS*4-1, GPIO (LED/SW) and a down-counting
// timer (TRELOAD/TCOUNT/TCTRL). Unmapped accesses still complete.
module mio_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_WORDS   = 1024,
    parameter int unsigned RAM_WAIT    = 1,
    parameter logic [31:0] UNMAPPED_RD = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    mio_responder_if.slave   bus,
    output logic             int_out,
    input  logic [15:0]      sw_in,
    output logic [15:0]      led_out
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt, wait_cnt_nxt;

    logic [31:0] addr_w;
    logic        is_ram;
    logic        req;
    logic        ram_en;
    logic        ram_we;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] ram_rdata;
    logic [31:0] rd_mux;

    logic [15:0] sw_meta, sw_sync;

    logic [31:0] reload, reload_nxt;
    logic [31:0] count, count_nxt;
    logic        enable, enable_nxt;
    logic        pending, pending_nxt;

    // Address bits [1:0] are masked off here so the decode is word aligned.
    assign addr_w = bus.addr_bus & ~32'h3;
    assign is_ram = (bus.addr_bus[31:AW+2] == '0);

    // A request is only accepted in IDLE; that edge is the commit point.
    assign req    = (state == IDLE) && bus.cpu_mio;
    assign ram_en = req && is_ram;
    assign ram_we = ram_en && bus.mem_w;
    assign reg_wr = req && !is_ram && bus.mem_w;
    assign reg_rd = req && !is_ram && !bus.mem_w;

    mio_ram #(
        .RAM_WORDS (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (bus.addr_bus[AW+1:2]),
        .wdata (bus.data_from_cpu),
        .rdata (ram_rdata)
    );

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            IDLE: begin
                if (bus.cpu_mio) begin
                    if (is_ram) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = 3'(RAM_WAIT);
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign bus.mio_ready = (state == DONE);

    // ---------------- read data ----------------
    always_comb begin
        rd_mux = UNMAPPED_RD;
        unique case (addr_w)
            ADDR_LED:     rd_mux = {16'h0000, led_out};
            ADDR_SW:      rd_mux = {16'h0000, sw_sync};
            ADDR_TRELOAD: rd_mux = reload;
            ADDR_TCOUNT:  rd_mux = count;
            ADDR_TCTRL: begin
                rd_mux             = '0;
                rd_mux[TCTRL_EN]   = enable;
                rd_mux[TCTRL_PEND] = pending;
            end
            default:      rd_mux = UNMAPPED_RD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_to_cpu <= '0;
        end else if (reg_rd) begin
            bus.data_to_cpu <= rd_mux;
        end else if (state == WAIT && wait_cnt == '0) begin
            bus.data_to_cpu <= ram_rdata;
        end
    end

    // ---------------- GPIO ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (reg_wr && addr_w == ADDR_LED) begin
                led_out <= bus.data_from_cpu[15:0];
            end
        end
    end

    // ---------------- timer ----------------
    // Expiry is applied after the clear so a coincident set wins; the 0->1
    // enable load is applied last (the counter was idle in that cycle).
    always_comb begin
        reload_nxt  = reload;
        count_nxt   = count;
        enable_nxt  = enable;
        pending_nxt = pending;

        if (reg_wr && addr_w == ADDR_TRELOAD) begin
            reload_nxt = bus.data_from_cpu;
        end
        if (reg_wr && addr_w == ADDR_TCTRL) begin
            enable_nxt = bus.data_from_cpu[TCTRL_EN];
            if (bus.data_from_cpu[TCTRL_PEND]) begin
                pending_nxt = 1'b0;
            end
        end
        if (enable) begin
            if (count == '0) begin
                count_nxt   = reload;
                pending_nxt = 1'b1;
            end else begin
                count_nxt = count - 32'd1;
            end
        end
        if (reg_wr && addr_w == ADDR_TCTRL && !enable && bus.data_from_cpu[TCTRL_EN]) begin
            count_nxt = reload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload  <= '0;
            count   <= '0;
            enable  <= 1'b0;
            pending <= 1'b0;
            int_out <= 1'b0;
        end else begin
            reload  <= reload_nxt;
            count   <= count_nxt;
            enable  <= enable_nxt;
            pending <= pending_nxt;
            int_out <= pending_nxt & enable_nxt;
        end
    end

endmodule

// File: doc/mio_responder.md
Name: mio_responder

Overview:
- Bus-side responder for the CPU's memory/IO port (cpu_mio, mem_w, address, write data, read data, MIO_ready, INT).
- Decodes each CPU request into one of three targets: on-chip data RAM, a GPIO register pair (LEDs and switches), or a down-counting timer.
- Returns read data and a one-cycle ready pulse to the CPU, and drives the CPU's INT input from the timer.
- Sits between the CPU wrapper and board I/O in the top level.

Parameters:
- RAM_WORDS, 1024, depth of the data RAM in 32-bit words; a power of two.
- RAM_WAIT, 1, extra wait cycles on every RAM access; range 0..7.
- UNMAPPED_RD, 32'h0000_0000, value returned for reads of unmapped addresses.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mio  in  1  request valid from the CPU.
- mem_w  in  1  1 = write, 0 = read; qualified by cpu_mio.
- addr_bus  in  32  byte address from the CPU; addr[1:0] is ignored.
- data_from_cpu  in  32  write data.
- data_to_cpu  out  32  read data; valid while mio_ready=1.
- mio_ready  out  1  one-cycle completion pulse (the CPU's MIO_ready).
- int_out  out  1  level interrupt to the CPU's INT.
- sw_in  in  16  board switches; asynchronous to clk.
- led_out  out  16  LED register.

Behaviour:
Address map (word aligned):
- RAM: 0x0000_0000 .. RAM_WORDS*4-1.
- LED: 0xE000_0000, read/write, bits[15:0]; upper bits read as 0.
- SW: 0xE000_0004, read-only; writes are ignored.
- TRELOAD: 0xF000_0000, read/write, 32 bits.
- TCOUNT: 0xF000_0004, read-only.
- TCTRL: 0xF000_0008. bit0 = enable (read/write). bit1 = pending (reads the flag; writing 1 clears it).
- Any other address is unmapped: writes are dropped, reads return UNMAPPED_RD, and ready is still returned so the bus never hangs.

Handshake:
- The CPU holds cpu_mio, mem_w, addr_bus and data_from_cpu stable until it sees mio_ready=1.
- The CPU drops cpu_mio, or presents the next request, in the cycle after that pulse.

FSM (IDLE, WAIT, DONE):
- IDLE, cpu_mio=1, register or unmapped target: the write commits or the read data is captured at this edge; next state DONE.
- IDLE, cpu_mio=1, RAM target: the RAM access is issued; next state WAIT with wait_cnt=RAM_WAIT.
- WAIT: wait_cnt decrements each cycle; go to DONE when it reaches 0. The RAM read result is latched into data_to_cpu on exit.
- DONE: mio_ready=1 for exactly one cycle; next state is always IDLE. A cpu_mio still high in that IDLE cycle is treated as a new request.
- Latency from request to ready: register access 1 cycle; RAM access 2+RAM_WAIT cycles.
- A RAM write commits once, on issue, regardless of how long the wait lasts.

Data path:
- data_to_cpu holds its last value outside DONE.
- For writes, data_to_cpu is don't-care.

Switches:
- sw_in passes through a 2-flop synchronizer; SW reads the synchronized value.

Timer:
- Each cycle with enable=1: if count==0, then count<=reload and pending<=1; otherwise count<=count-1. The period is reload+1 cycles.
- Writing TCTRL with enable going 0->1 loads count<=reload.
- Writing TRELOAD while the timer runs takes effect at the next expiry.
- If an expiry coincides with a write-1-to-clear of pending, the set wins and pending stays 1.
- int_out = pending & enable, registered.

Reset (synchronous, also mid-transaction):
- state=IDLE, mio_ready=0, data_to_cpu=0, led_out=0.
- reload=0, count=0, enable=0, pending=0, int_out=0.
- Any in-flight transaction is abandoned without a ready pulse.
- RAM contents are not cleared.

Decomposition:
- Package mio_pkg holds the address constants (LED, SW, TRELOAD, TCOUNT, TCTRL), the TCTRL bit indices, and the FSM state enum {IDLE, WAIT, DONE}.
- One sub-module, mio_ram: single-port synchronous RAM with word writes and one-cycle registered read, parameterised by RAM_WORDS.
- Decode, FSM, GPIO and timer stay in mio_responder.

Test Plan:
- Write 0x1234_5678 to RAM 0x10, then read 0x10 with RAM_WAIT=1. Expect mio_ready exactly 3 cycles after the request, data_to_cpu=0x1234_5678, and a single-cycle pulse.
- Write 0xFFFF_A5A5 to 0xE000_0000. Expect led_out=16'hA5A5 and ready 1 cycle after the request. Reading it back returns 0x0000_A5A5.
- Set sw_in=16'h00F0, wait 3 cycles, read 0xE000_0004. Expect 0x0000_00F0. A write to this address leaves read data unchanged.
- Write TRELOAD=4, then TCTRL=1. Expect int_out to rise 5 cycles after enable. Writing TCTRL=3 clears it, and it re-asserts 5 cycles later.
- Coincidence case: write-1-clear of pending lands in the same cycle as an expiry. Expect pending to remain 1.
- Read 0x8000_0000. Expect data_to_cpu=UNMAPPED_RD with ready. Assert reset while in WAIT: no ready pulse, all outputs 0 next cycle, and RAM contents are preserved.
